// File: rtl/transmissao_cubo_uc_if.sv
// Signal bundle between the cube-transmission control unit and its surroundings:
// command handshake, serial transmitter handshake, sticker RAM addressing, status.
interface transmissao_cubo_uc_if;
  logic       iniciar;
  logic       pronto_serial;
  logic [2:0] dados_pixel;
  logic       partida_serial;
  logic [7:0] dado_serial;
  logic [2:0] addr_face;
  logic [1:0] addr_linha;
  logic [1:0] addr_coluna;
  logic       ocupado;
  logic       fim;
  logic       erro;
  logic [3:0] db_estado;

  // The control unit drives the transmitter and RAM addresses.
  modport master (
    input  iniciar, pronto_serial, dados_pixel,
    output partida_serial, dado_serial, addr_face, addr_linha, addr_coluna,
    output ocupado, fim, erro, db_estado
  );

  modport slave (
    output iniciar, pronto_serial, dados_pixel,
    input  partida_serial, dado_serial, addr_face, addr_linha, addr_coluna,
    input  ocupado, fim, erro, db_estado
  );
endinterface

// File: rtl/transmissao_cubo_uc.sv
// Control unit that streams the full cube state (face header, sticker codes,
// frame terminator) through the byte-wide serial transmitter, with a per-byte timeout.
module transmissao_cubo_uc #(
  parameter int unsigned N_FACES    = 6,
  parameter int unsigned N_LINHAS   = 3,
  parameter int unsigned N_COLUNAS  = 3,
  parameter logic [7:0]  BASE_ASCII = 8'h30,
  parameter logic [7:0]  TERMINADOR = 8'h0A,
  parameter int unsigned TIMEOUT    = 1000000
) (
  input  logic                  clock,
  input  logic                  reset,
  transmissao_cubo_uc_if.master bus
);
  localparam int unsigned   TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);
  localparam logic [2:0]    FACE_MAX  = 3'(N_FACES - 1);
  localparam logic [1:0]    LIN_MAX   = 2'(N_LINHAS - 1);
  localparam logic [1:0]    COL_MAX   = 2'(N_COLUNAS - 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    ENVIA_CAB   = 4'h2,
    ESPERA_CAB  = 4'h3,
    CARREGA     = 4'h4,
    ENVIA_PIX   = 4'h5,
    ESPERA_PIX  = 4'h6,
    PROXIMO     = 4'h7,
    ENVIA_TERM  = 4'h8,
    ESPERA_TERM = 4'h9,
    FINAL       = 4'hA,
    ERRO        = 4'hE
  } estado_t;

  estado_t       r_estado;
  estado_t       w_apos_espera;
  logic          r_partida;
  logic          r_ocupado;
  logic          r_fim;
  logic          r_erro;
  logic [7:0]    r_dado;
  logic [2:0]    r_face;
  logic [1:0]    r_linha;
  logic [1:0]    r_coluna;
  logic [TW-1:0] r_timer;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_apos_espera = FINAL;
    case (r_estado)
      ESPERA_CAB: w_apos_espera = CARREGA;
      ESPERA_PIX: w_apos_espera = PROXIMO;
      default:    ;
    endcase
  end

  // NOTE: state and outputs use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado  <= INICIAL;
      r_partida <= 1'b0;
      r_ocupado <= 1'b0;
      r_fim     <= 1'b0;
      r_erro    <= 1'b0;
      r_dado    <= '0;
      r_face    <= '0;
      r_linha   <= '0;
      r_coluna  <= '0;
      r_timer   <= '0;
    end else begin
      r_partida <= 1'b0;
      r_fim     <= 1'b0;
      case (r_estado)
        INICIAL: if (bus.iniciar) begin
          r_estado  <= PREPARA;
          r_ocupado <= 1'b1;
        end
        PREPARA: begin
          r_face    <= '0;
          r_linha   <= '0;
          r_coluna  <= '0;
          r_timer   <= '0;
          r_dado    <= BASE_ASCII;
          r_partida <= 1'b1;
          r_estado  <= ENVIA_CAB;
        end
        ENVIA_CAB: begin
          r_timer  <= '0;
          r_estado <= ESPERA_CAB;
        end
        ENVIA_PIX: begin
          r_timer  <= '0;
          r_estado <= ESPERA_PIX;
        end
        ENVIA_TERM: begin
          r_timer  <= '0;
          r_estado <= ESPERA_TERM;
        end
        // A done pulse on the expiry cycle still counts as a normal completion.
        ESPERA_CAB, ESPERA_PIX, ESPERA_TERM: begin
          if (bus.pronto_serial) begin
            r_estado <= w_apos_espera;
            r_fim    <= (w_apos_espera == FINAL);
          end else if (r_timer == TIMER_MAX) begin
            r_estado  <= ERRO;
            r_erro    <= 1'b1;
            r_ocupado <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        CARREGA: begin
          r_dado    <= BASE_ASCII + {5'b0, bus.dados_pixel};
          r_partida <= 1'b1;
          r_estado  <= ENVIA_PIX;
        end
        PROXIMO: begin
          r_estado <= CARREGA;
          if (r_coluna == COL_MAX) begin
            r_coluna <= '0;
            if (r_linha == LIN_MAX) begin
              r_linha   <= '0;
              r_partida <= 1'b1;
              // Last face wraps the address back to zero before the terminator.
              if (r_face == FACE_MAX) begin
                r_face   <= '0;
                r_dado   <= TERMINADOR;
                r_estado <= ENVIA_TERM;
              end else begin
                r_face   <= r_face + 3'd1;
                r_dado   <= BASE_ASCII + {5'b0, r_face + 3'd1};
                r_estado <= ENVIA_CAB;
              end
            end else begin
              r_linha <= r_linha + 2'd1;
            end
          end else begin
            r_coluna <= r_coluna + 2'd1;
          end
        end
        FINAL: begin
          r_estado  <= INICIAL;
          r_ocupado <= 1'b0;
        end
        ERRO: if (bus.iniciar) begin
          r_estado  <= PREPARA;
          r_erro    <= 1'b0;
          r_ocupado <= 1'b1;
        end
        default: begin
          r_estado  <= INICIAL;
          r_ocupado <= 1'b0;
          r_erro    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.partida_serial = r_partida;
  assign bus.dado_serial    = r_dado;
  assign bus.addr_face      = r_face;
  assign bus.addr_linha     = r_linha;
  assign bus.addr_coluna    = r_coluna;
  assign bus.ocupado        = r_ocupado;
  assign bus.fim            = r_fim;
  assign bus.erro           = r_erro;
  assign bus.db_estado      = r_estado;
endmodule

// File: tb/tb_transmissao_cubo_uc.sv
// Bench for transmissao_cubo_uc: start-up vector table, a transmitter and sticker RAM
// model, and whole-frame checks against a byte list built from the frame rules.
module tb_transmissao_cubo_uc;
  localparam int         N_FACES   = 6;
  localparam int         N_LINHAS  = 3;
  localparam int         N_COLUNAS = 3;
  localparam logic [7:0] BASE      = 8'h30;
  localparam logic [7:0] TERM      = 8'h0A;
  localparam int         TIMEOUT   = 50;

  logic clock = 1'b0;
  logic reset;

  transmissao_cubo_uc_if bus ();

  transmissao_cubo_uc #(
    .N_FACES   (N_FACES),
    .N_LINHAS  (N_LINHAS),
    .N_COLUNAS (N_COLUNAS),
    .BASE_ASCII(BASE),
    .TERMINADOR(TERM),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clock = ~clock;

  // Sticker RAM: contents readable as soon as the address settles.
  logic [2:0] mem [0:7][0:3][0:3];
  assign bus.dados_pixel = mem[bus.addr_face][bus.addr_linha][bus.addr_coluna];

  typedef struct {
    logic       iniciar;
    logic       pronto;
    logic [3:0] estado;
    logic       partida;
    logic       ocupado;
    logic [7:0] dado;
    logic       chk_dado;
    logic [1:0] coluna;
  } vec_t;

  vec_t vecs [11];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tx_cnt, tx_delay, tx_mute;
  bit tx_rand;
  int fim_cnt, erro_cyc, last_partida_cyc;
  bit erro_seen, prev_fim, found;

  logic [7:0] byte_q [$];
  logic [6:0] addr_q [$];
  logic [7:0] exp_bytes [$];
  logic [6:0] exp_addr [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One clock with the transmitter model and frame monitor attached.
  task automatic cycle();
    tick();
    cyc++;
    bus.pronto_serial = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        bus.pronto_serial = 1'b1;
        if (byte_q.size() > 0) check("dado_estavel", bus.dado_serial, byte_q[$]);
      end
    end
    if (bus.partida_serial) begin
      check("partida_em_envia",
            (bus.db_estado == 4'h2) || (bus.db_estado == 4'h5) || (bus.db_estado == 4'h8), 1);
      byte_q.push_back(bus.dado_serial);
      addr_q.push_back({bus.addr_face, bus.addr_linha, bus.addr_coluna});
      last_partida_cyc = cyc;
      if (byte_q.size() - 1 != tx_mute) tx_cnt = tx_rand ? int'($urandom_range(1, 20)) : tx_delay;
    end
    if (prev_fim) begin
      check("ocupado_apos_fim", bus.ocupado, 0);
      check("fim_um_ciclo", bus.fim, 0);
      check("addr_zero_apos_fim", {bus.addr_face, bus.addr_linha, bus.addr_coluna}, 0);
    end
    prev_fim = bus.fim;
    if (bus.fim) fim_cnt++;
    if (bus.erro && !erro_seen) begin
      erro_seen = 1'b1;
      erro_cyc  = cyc;
    end
  endtask

  task automatic fill_mem_padrao();
    for (int f = 0; f < 8; f++)
      for (int l = 0; l < 4; l++)
        for (int c = 0; c < 4; c++)
          mem[f][l][c] = 3'((f + l + c) % 6);
  endtask

  // Expected frame: per face a header then row-major stickers, then the terminator.
  function automatic void build_model();
    exp_bytes.delete();
    exp_addr.delete();
    for (int f = 0; f < N_FACES; f++) begin
      exp_bytes.push_back(8'(BASE + f));
      exp_addr.push_back({3'(f), 2'd0, 2'd0});
      for (int l = 0; l < N_LINHAS; l++)
        for (int c = 0; c < N_COLUNAS; c++) begin
          exp_bytes.push_back(8'(BASE + mem[f][l][c]));
          exp_addr.push_back({3'(f), 2'(l), 2'(c)});
        end
    end
    exp_bytes.push_back(TERM);
    exp_addr.push_back(7'd0);
  endfunction

  task automatic run_frame(input bit hold);
    bit ended;
    byte_q.delete();
    addr_q.delete();
    fim_cnt   = 0;
    erro_seen = 1'b0;
    prev_fim  = 1'b0;
    tx_cnt    = 0;
    bus.iniciar = 1'b1;
    cycle();
    check("erro_limpo", bus.erro, 0);
    check("estado_prepara", bus.db_estado, 4'h1);
    bus.iniciar = hold;
    ended = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (!bus.ocupado) begin
        ended = 1'b1;
        break;
      end
      cycle();
    end
    check("frame_termina", ended, 1);
  endtask

  task automatic check_frame(input string name);
    build_model();
    check($sformatf("%s_n_bytes", name), byte_q.size(), exp_bytes.size());
    for (int i = 0; i < exp_bytes.size() && i < byte_q.size(); i++) begin
      check($sformatf("%s_byte%0d", name, i), byte_q[i], exp_bytes[i]);
      check($sformatf("%s_addr%0d", name, i), addr_q[i], exp_addr[i]);
    end
    check($sformatf("%s_fim", name), fim_cnt, 1);
    check($sformatf("%s_sem_erro", name), erro_seen, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          ini   pronto estado partida ocup  dado   chk   col
    vecs[0]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 4'h1, 1'b0, 1'b1, 8'h00, 1'b0, 2'd0};
    vecs[2]  = '{1'b0, 1'b0, 4'h2, 1'b1, 1'b1, 8'h30, 1'b1, 2'd0};
    vecs[3]  = '{1'b1, 1'b0, 4'h3, 1'b0, 1'b1, 8'h30, 1'b1, 2'd0};
    vecs[4]  = '{1'b0, 1'b1, 4'h4, 1'b0, 1'b1, 8'h00, 1'b0, 2'd0};
    vecs[5]  = '{1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 8'h30, 1'b1, 2'd0};
    vecs[6]  = '{1'b0, 1'b1, 4'h6, 1'b0, 1'b1, 8'h30, 1'b1, 2'd0};
    vecs[7]  = '{1'b0, 1'b0, 4'h6, 1'b0, 1'b1, 8'h30, 1'b1, 2'd0};
    vecs[8]  = '{1'b0, 1'b1, 4'h7, 1'b0, 1'b1, 8'h00, 1'b0, 2'd0};
    vecs[9]  = '{1'b0, 1'b0, 4'h4, 1'b0, 1'b1, 8'h00, 1'b0, 2'd1};
    vecs[10] = '{1'b0, 1'b0, 4'h5, 1'b1, 1'b1, 8'h31, 1'b1, 2'd1};

    fill_mem_padrao();
    bus.iniciar       = 1'b0;
    bus.pronto_serial = 1'b0;
    reset    = 1'b0;
    tx_cnt   = 0;
    tx_mute  = -1;
    tx_delay = 11;
    tx_rand  = 1'b0;
    repeat (3) tick();
    check("reset_estado", bus.db_estado, 0);
    check("reset_saidas", {bus.partida_serial, bus.dado_serial, bus.addr_face, bus.addr_linha,
                           bus.addr_coluna, bus.ocupado, bus.fim, bus.erro}, 0);
    reset = 1'b1;

    // Start-up sequence, including stray pronto and iniciar pulses.
    for (int i = 0; i < 11; i++) begin
      bus.iniciar       = vecs[i].iniciar;
      bus.pronto_serial = vecs[i].pronto;
      tick();
      check($sformatf("v%0d_estado", i), bus.db_estado, vecs[i].estado);
      check($sformatf("v%0d_partida", i), bus.partida_serial, vecs[i].partida);
      check($sformatf("v%0d_ocupado", i), bus.ocupado, vecs[i].ocupado);
      check($sformatf("v%0d_coluna", i), bus.addr_coluna, vecs[i].coluna);
      if (vecs[i].chk_dado) check($sformatf("v%0d_dado", i), bus.dado_serial, vecs[i].dado);
    end
    bus.iniciar       = 1'b0;
    bus.pronto_serial = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;

    // Full frame with the (f+l+c)%6 pattern and an 11-cycle transmitter.
    run_frame(1'b0);
    check_frame("cheio");
    check("pixel_211", (byte_q.size() > 25) ? byte_q[25] : 8'h00, 8'h34);
    check("cheio_inicial", bus.db_estado, 0);

    // Random sticker contents and random transmitter latency per byte.
    tx_rand = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int f = 0; f < 8; f++)
        for (int l = 0; l < 4; l++)
          for (int c = 0; c < 4; c++)
            mem[f][l][c] = 3'($urandom_range(0, 7));
      run_frame(1'b0);
      check_frame($sformatf("rand%0d", r));
    end
    tx_rand = 1'b0;
    fill_mem_padrao();

    // iniciar held high for the whole frame: one frame, then restart from INICIAL only.
    run_frame(1'b1);
    check_frame("segurado");
    check("segurado_inicial", bus.db_estado, 0);
    cycle();
    check("reinicio_imediato", bus.db_estado, 4'h1);
    bus.iniciar = 1'b0;

    // Reset while waiting on a sticker byte of face 3.
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (bus.db_estado == 4'h6 && bus.addr_face == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    check("achou_face3", found, 1);
    reset = 1'b0;
    cycle();
    check("reset_meio_estado", bus.db_estado, 0);
    check("reset_meio_saidas", {bus.partida_serial, bus.dado_serial, bus.addr_face, bus.addr_linha,
                                bus.addr_coluna, bus.ocupado, bus.fim, bus.erro}, 0);
    reset = 1'b1;
    tx_cnt = 0;
    bus.pronto_serial = 1'b0;
    run_frame(1'b0);
    check_frame("apos_reset");

    // Transmitter never answers the 4th byte.
    tx_mute = 3;
    run_frame(1'b0);
    check("to_erro", bus.erro, 1);
    check("to_estado", bus.db_estado, 4'hE);
    check("to_ocupado", bus.ocupado, 0);
    check("to_n_bytes", byte_q.size(), 4);
    check("to_latencia", erro_cyc - last_partida_cyc - 1, TIMEOUT);
    check("to_addr", {bus.addr_face, bus.addr_linha, bus.addr_coluna}, {3'd0, 2'd0, 2'd2});
    repeat (20) cycle();
    check("to_sem_partida", byte_q.size(), 4);
    check("to_erro_mantido", bus.erro, 1);
    tx_mute = -1;
    run_frame(1'b0);
    check_frame("pos_erro");

    // pronto arrives on the very cycle the timeout would expire.
    tx_delay = TIMEOUT;
    run_frame(1'b0);
    check_frame("pronto_no_limite");
    check("limite_erro", bus.erro, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/transmissao_cubo_uc.md
Name: transmissao_cubo_uc

Overview:
- Control unit that sequences transmission of the complete cube state (6 faces × 3×3 stickers) over the existing byte-wide serial transmitter.
- Walks face/row/column addresses into the pixel memory and builds each byte: a face header, then 9 sticker codes per face, then one frame terminator.
- Drives the transmitter start pulse and waits for its done pulse, with a timeout.
- Sits between the top-level command logic (iniciar/fim) and the serial TX datapath plus sticker RAM.

Parameters:
N_FACES, 6, number of faces per frame (1..8)
N_LINHAS, 3, rows per face (1..4)
N_COLUNAS, 3, columns per face (1..4)
BASE_ASCII, 8'h30, offset added to face index and sticker code
TERMINADOR, 8'h0A, final byte of frame
TIMEOUT, 20'd1000000, max clock cycles waiting pronto_serial per byte

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
iniciar  in  1  start frame; sampled only in INICIAL
pronto_serial  in  1  1-cycle pulse from transmitter: byte finished
dados_pixel  in  3  sticker code from RAM; valid 1 cycle after address change
partida_serial  out  1  1-cycle pulse: transmitter loads dado_serial
dado_serial  out  8  byte to transmit; registered, stable from partida until pronto
addr_face  out  3  face address to RAM
addr_linha  out  2  row address to RAM
addr_coluna  out  2  column address to RAM
ocupado  out  1  high in every state except INICIAL and ERRO
fim  out  1  1-cycle pulse when terminator has been sent
erro  out  1  high in ERRO (timeout); held until iniciar or reset
db_estado  out  4  current state code

Behaviour:
- Reset (reset=0 at a clock edge): state INICIAL; all outputs 0; counters cleared. Reset overrides everything, including mid-byte; a pending transmitter byte is abandoned.
- States (db_estado code):
  - INICIAL(0): iniciar=1 → PREPARA.
  - PREPARA(1): face/row/col ← 0; timeout counter ← 0 → ENVIA_CAB.
  - ENVIA_CAB(2): dado_serial ← BASE_ASCII + addr_face; partida_serial=1 for this cycle → ESPERA_CAB.
  - ESPERA_CAB(3): pronto_serial → CARREGA.
  - CARREGA(4): address has been stable ≥1 cycle; dados_pixel sampled at end of cycle → ENVIA_PIX.
  - ENVIA_PIX(5): dado_serial ← BASE_ASCII + {5'b0, sampled pixel}; partida pulse → ESPERA_PIX.
  - ESPERA_PIX(6): pronto_serial → PROXIMO.
  - PROXIMO(7): increment column. At column wrap (N_COLUNAS-1 → 0), increment row. At row wrap, increment face and go to ENVIA_CAB, or go to ENVIA_TERM if the face was N_FACES-1. Otherwise → CARREGA.
  - ENVIA_TERM(8): dado_serial ← TERMINADOR; partida pulse → ESPERA_TERM.
  - ESPERA_TERM(9): pronto_serial → FINAL.
  - FINAL(A): fim=1 for exactly one cycle → INICIAL.
  - ERRO(E): erro=1. iniciar → PREPARA, clearing erro on that transition.
- Timeout: counter clears on entry to every ESPERA_* state and increments each cycle while there. If it reaches TIMEOUT-1 with no pronto_serial → ERRO, and addresses freeze. pronto_serial in the same cycle as expiry wins: normal transition.
- partida_serial is high only in ENVIA_* states, exactly 1 cycle per byte. Frame is N_FACES×(1+N_LINHAS×N_COLUNAS)+1 bytes = 61 at defaults.
- pronto_serial outside ESPERA_* is ignored. iniciar while ocupado=1 is ignored.
- Address order: face-major, then row, then column (column fastest). Addresses change only in PREPARA/PROXIMO and stay 0 in INICIAL after FINAL.
- Latency: iniciar → first partida = 2 cycles. Each pixel byte costs 3 cycles plus the transmitter time.

Test Plan:
- Full frame, TX model pulses pronto 11 cycles after each partida; RAM returns (face+row+col)%6 → exactly 61 partidas. Bytes are 0x30, then 9 pixel bytes, … 0x35, 9 pixel bytes, then 0x0A. fim pulses once, ocupado falls the cycle after fim, erro=0.
- Address trace check: (f,l,c) sequence (0,0,0),(0,0,1),(0,0,2),(0,1,0)…(5,2,2); dado_serial for pixel 4 at (2,1,1) = 0x34.
- Timeout: TIMEOUT=50, TX model never answers 4th byte → erro=1 exactly 50 cycles after entering ESPERA_PIX, ocupado=0, no further partida. iniciar → full 61-byte frame restarts from (0,0,0) and erro clears.
- Spurious stimuli: pronto pulse in INICIAL and during ENVIA_PIX; iniciar held high for whole frame → no extra partida, exactly one frame, then immediate restart only from INICIAL.
- Reset mid-frame (reset=0 during ESPERA_PIX at face 3) → next cycle all outputs 0, db_estado=0. Subsequent iniciar sends a complete frame from header 0x30.
- Simultaneous pronto and timeout expiry on the same cycle → transition to PROXIMO, erro stays 0.
